// File: rtl/lc3_mem_arbiter_if.sv
// Signal bundle between the LC3 core, the unified-memory arbiter and the backing memory.
// Handshake: a port raises instrmem_rd/data_req with its address/data stable and holds it until its
// one-cycle complete_* pulse; requests are only sampled while the arbiter is idle, so a request still
// high after its pulse is taken as a fresh transaction.
interface lc3_mem_arbiter_if;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport slave (
    input  instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_din, mem_rdata,
    output Instr_dout, complete_instr, Data_dout, complete_data,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_din, mem_rdata,
    input  Instr_dout, complete_instr, Data_dout, complete_data,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Serialises LC3 fetch and MEM-stage data accesses onto one single-ported memory.
// Data wins over fetch until STARVE_MAX consecutive data grants have made the fetch wait.
module lc3_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  lc3_mem_arbiter_if.slave bus,
  output logic [1:0]       state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC_I = 2'd1, ACC_D = 2'd2, DONE = 2'd3} state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STARVE_MAX);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic          is_instr;
  logic          is_write;
  logic          grant_i, grant_d;
  logic          fetch_due, in_acc, last;

  assign fetch_due = (STARVE_MAX != 0) && (streak == STREAK_TOP);
  assign in_acc    = (state == ACC_I) || (state == ACC_D);
  assign last      = in_acc && (cnt == CNT_LAST);
  assign state_dbg = state;

  always_comb begin
    state_nxt          = state;
    grant_i            = 1'b0;
    grant_d            = 1'b0;
    bus.mem_en         = in_acc;
    bus.mem_we         = is_write && (state == ACC_D);
    bus.busy           = (state != IDLE);
    bus.complete_instr = (state == DONE) && is_instr;
    bus.complete_data  = (state == DONE) && !is_instr;
    case (state)
      IDLE: begin
        if (bus.data_req && !(bus.instrmem_rd && fetch_due)) begin
          grant_d   = 1'b1;
          state_nxt = ACC_D;
        end else if (bus.instrmem_rd) begin
          grant_i   = 1'b1;
          state_nxt = ACC_I;
        end
      end
      ACC_I, ACC_D: if (last) state_nxt = DONE;
      DONE:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      streak         <= '0;
      is_instr       <= 1'b0;
      is_write       <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.Instr_dout <= '0;
      bus.Data_dout  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        is_instr     <= 1'b1;
        is_write     <= 1'b0;
        bus.mem_addr <= bus.pc;
        streak       <= '0;
      end
      if (grant_d) begin
        is_instr      <= 1'b0;
        is_write      <= !bus.Data_rd;
        bus.mem_addr  <= bus.Data_addr;
        bus.mem_wdata <= bus.Data_din;
        // Streak only grows while a fetch is actually being held off.
        if (!bus.instrmem_rd)        streak <= '0;
        else if (streak != STREAK_TOP) streak <= streak + 1'b1;
      end
      if (in_acc) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          if (state == ACC_I)  bus.Instr_dout <= bus.mem_rdata;
          else if (!is_write)  bus.Data_dout  <= bus.mem_rdata;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Three instances share the core-side inputs: main (2,4), strict priority (2,0) and single-cycle (1,4).
module tb_lc3_mem_arbiter;
  localparam int LAT = 2;
  localparam int SMAX = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic        instrmem_rd = 1'b0, data_req = 1'b0, Data_rd = 1'b1;
  logic [15:0] pc = '0, Data_addr = '0, Data_din = '0;
  logic [15:0] l1_rdata = '0;
  logic [1:0]  dbg_m, dbg_s0, dbg_l1;

  lc3_mem_arbiter_if m_if();
  lc3_mem_arbiter_if s0_if();
  lc3_mem_arbiter_if l1_if();

  assign m_if.instrmem_rd = instrmem_rd; assign s0_if.instrmem_rd = instrmem_rd; assign l1_if.instrmem_rd = instrmem_rd;
  assign m_if.pc = pc;                   assign s0_if.pc = pc;                   assign l1_if.pc = pc;
  assign m_if.data_req = data_req;       assign s0_if.data_req = data_req;       assign l1_if.data_req = data_req;
  assign m_if.Data_rd = Data_rd;         assign s0_if.Data_rd = Data_rd;         assign l1_if.Data_rd = Data_rd;
  assign m_if.Data_addr = Data_addr;     assign s0_if.Data_addr = Data_addr;     assign l1_if.Data_addr = Data_addr;
  assign m_if.Data_din = Data_din;       assign s0_if.Data_din = Data_din;       assign l1_if.Data_din = Data_din;
  assign s0_if.mem_rdata = s0_if.mem_addr ^ 16'h5A5A;
  assign l1_if.mem_rdata = l1_rdata;

  lc3_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset), .bus(m_if.slave), .state_dbg(dbg_m));
  lc3_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(0)) dut_s0 (
    .clock(clock), .reset(reset), .bus(s0_if.slave), .state_dbg(dbg_s0));
  lc3_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_l1 (
    .clock(clock), .reset(reset), .bus(l1_if.slave), .state_dbg(dbg_l1));

  // {mem_en, mem_we, busy, complete_instr, complete_data}
  wire [4:0] ctl_m  = {m_if.mem_en, m_if.mem_we, m_if.busy, m_if.complete_instr, m_if.complete_data};
  wire [4:0] ctl_s0 = {s0_if.mem_en, s0_if.mem_we, s0_if.busy, s0_if.complete_instr, s0_if.complete_data};
  wire [4:0] ctl_l1 = {l1_if.mem_en, l1_if.mem_we, l1_if.busy, l1_if.complete_instr, l1_if.complete_data};

  // Backing memory for the main instance: sparse array, unwritten words read as a hash of the address.
  logic [15:0] mem_arr [logic [15:0]];
  logic [15:0] shadow  [logic [15:0]];
  logic [16:0] exp_q[$];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] mem_peek(input logic [15:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] shadow_peek(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  initial begin
    m_if.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (m_if.mem_en === 1'b1 && m_if.mem_we === 1'b1) mem_arr[m_if.mem_addr] = m_if.mem_wdata;
      m_if.mem_rdata = mem_peek(m_if.mem_addr);
    end
  end

  task automatic apply_reset();
    instrmem_rd = 1'b0; data_req = 1'b0; Data_rd = 1'b1;
    pc = '0; Data_addr = '0; Data_din = '0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({m_if.Instr_dout, m_if.Data_dout, ctl_m, m_if.mem_addr, m_if.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%h/%b/%h/%h required all zero",
               m_if.Instr_dout, m_if.Data_dout, ctl_m, m_if.mem_addr, m_if.mem_wdata);
    end
    checks++;
    if ({dbg_m, ctl_s0, ctl_l1} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%b/%b/%b required zero", dbg_m, ctl_s0, ctl_l1);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ctl_m !== 5'b00000) begin
      errors++;
      $display("FAIL idle_no_request got=%b required=00000", ctl_m);
    end
  endtask

  task automatic test_fetch();
    logic [4:0] exp;
    mem_arr[16'h3000] = 16'h1261;
    instrmem_rd = 1'b1; pc = 16'h3000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      exp = (c <= 2) ? 5'b10100 : (c == 3) ? 5'b00110 : 5'b00000;
      checks++;
      if (ctl_m !== exp) begin
        errors++;
        $display("FAIL fetch_ctl cycle=%0d got=%b required=%b", c, ctl_m, exp);
      end
      if (c <= 2) begin
        checks++;
        if (m_if.mem_addr !== 16'h3000) begin
          errors++;
          $display("FAIL fetch_addr cycle=%0d got=%h required=3000", c, m_if.mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (m_if.Instr_dout !== 16'h1261) begin
          errors++;
          $display("FAIL fetch_data got=%h required=1261", m_if.Instr_dout);
        end
        instrmem_rd = 1'b0;
      end
    end
  endtask

  task automatic test_write();
    logic [4:0] exp;
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4000; Data_din = 16'hBEEF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      exp = (c <= 2) ? 5'b11100 : (c == 3) ? 5'b00101 : 5'b00000;
      checks++;
      if (ctl_m !== exp) begin
        errors++;
        $display("FAIL write_ctl cycle=%0d got=%b required=%b", c, ctl_m, exp);
      end
      if (c <= 2) begin
        checks++;
        if ({m_if.mem_addr, m_if.mem_wdata} !== {16'h4000, 16'hBEEF}) begin
          errors++;
          $display("FAIL write_bus cycle=%0d got=%h/%h required=4000/beef", c, m_if.mem_addr, m_if.mem_wdata);
        end
      end
      if (c == 3) begin
        checks++;
        if (m_if.Data_dout !== 16'h0000) begin
          errors++;
          $display("FAIL write_dout_held got=%h required=0000", m_if.Data_dout);
        end
        data_req = 1'b0; Data_rd = 1'b1;
      end
    end
    checks++;
    if (mem_peek(16'h4000) !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_memory got=%h required=beef", mem_peek(16'h4000));
    end
  endtask

  task automatic test_priority();
    logic [4:0] exp;
    instrmem_rd = 1'b1; pc = 16'h3002;
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h5000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      case (c)
        1, 2, 5, 6: exp = 5'b10100;
        3:          exp = 5'b00101;
        7:          exp = 5'b00110;
        default:    exp = 5'b00000;
      endcase
      checks++;
      if (ctl_m !== exp) begin
        errors++;
        $display("FAIL priority_ctl cycle=%0d got=%b required=%b", c, ctl_m, exp);
      end
      if (c == 1 || c == 5) begin
        checks++;
        if (m_if.mem_addr !== ((c == 1) ? 16'h5000 : 16'h3002)) begin
          errors++;
          $display("FAIL priority_addr cycle=%0d got=%h", c, m_if.mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (m_if.Data_dout !== init_val(16'h5000)) begin
          errors++;
          $display("FAIL priority_data got=%h required=%h", m_if.Data_dout, init_val(16'h5000));
        end
        data_req = 1'b0;
      end
      if (c == 7) begin
        checks++;
        if (m_if.Instr_dout !== init_val(16'h3002)) begin
          errors++;
          $display("FAIL priority_instr got=%h required=%h", m_if.Instr_dout, init_val(16'h3002));
        end
        instrmem_rd = 1'b0;
      end
    end
  endtask

  task automatic test_starvation();
    int s0_d, s0_i;
    logic [16:0] item;
    apply_reset();
    exp_q.delete();
    for (int k = 0; k < 15; k++) exp_q.push_back({((k % 5) == 4), 16'h0000});
    s0_d = 0; s0_i = 0;
    instrmem_rd = 1'b1; pc = 16'h3004;
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4001;
    for (int c = 1; c <= 62; c++) begin
      @(negedge clock);
      if (m_if.complete_instr === 1'b1 || m_if.complete_data === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL starve_extra cycle=%0d got complete, required none", c);
        end else begin
          item = exp_q.pop_front();
          if (m_if.complete_instr !== item[16]) begin
            errors++;
            $display("FAIL starve_order cycle=%0d got instr=%b required instr=%b", c, m_if.complete_instr, item[16]);
          end
        end
      end
      if (s0_if.complete_data === 1'b1) s0_d++;
      if (s0_if.complete_instr === 1'b1) s0_i++;
    end
    instrmem_rd = 1'b0; data_req = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL starve_count got %0d missing grants required 0", exp_q.size());
    end
    checks++;
    if (s0_d != 15 || s0_i != 0) begin
      errors++;
      $display("FAIL strict_priority got data=%0d fetch=%0d required data=15 fetch=0", s0_d, s0_i);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [4:0] exp;
    apply_reset();
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4002; Data_din = 16'h1234;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      checks++;
      if (ctl_m !== 5'b11100) begin
        errors++;
        $display("FAIL abort_pre cycle=%0d got=%b required=11100", c, ctl_m);
      end
    end
    #2 reset = 1'b1;
    data_req = 1'b0; Data_rd = 1'b1;
    #1;
    checks++;
    if (ctl_m !== 5'b00000) begin
      errors++;
      $display("FAIL abort_immediate got=%b required=00000", ctl_m);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (ctl_m !== 5'b00000) begin
      errors++;
      $display("FAIL abort_no_complete got=%b required=00000", ctl_m);
    end
    instrmem_rd = 1'b1; pc = 16'h3000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      exp = (c <= 2) ? 5'b10100 : (c == 3) ? 5'b00110 : 5'b00000;
      checks++;
      if (ctl_m !== exp) begin
        errors++;
        $display("FAIL abort_recover cycle=%0d got=%b required=%b", c, ctl_m, exp);
      end
      if (c == 3) begin
        checks++;
        if (m_if.Instr_dout !== 16'h1261) begin
          errors++;
          $display("FAIL abort_recover_data got=%h required=1261", m_if.Instr_dout);
        end
        instrmem_rd = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp;
    logic [15:0] rd_prev;
    apply_reset();
    l1_rdata = 16'($urandom);
    rd_prev = l1_rdata;
    instrmem_rd = 1'b1; pc = 16'h3006;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      exp = ((c % 3) == 1) ? 5'b10100 : ((c % 3) == 2) ? 5'b00110 : 5'b00000;
      checks++;
      if (ctl_l1 !== exp) begin
        errors++;
        $display("FAIL b2b_ctl cycle=%0d got=%b required=%b", c, ctl_l1, exp);
      end
      if ((c % 3) == 2) begin
        checks++;
        if (l1_if.Instr_dout !== rd_prev) begin
          errors++;
          $display("FAIL b2b_data cycle=%0d got=%h required=%h", c, l1_if.Instr_dout, rd_prev);
        end
      end
      l1_rdata = 16'($urandom);
      rd_prev = l1_rdata;
    end
    instrmem_rd = 1'b0;
  endtask

  // Transaction-level model: the arbiter is free from free_at onward; each grant occupies
  // LAT access cycles plus one completion cycle, then one idle cycle before the next grant.
  task automatic test_random(input int n);
    int          free_at, g_edge, streak, c;
    bit          active, g_instr, g_we, en, done;
    logic [15:0] g_addr, g_wdata, exp_instr, exp_data;
    logic [16:0] item;
    logic [4:0]  exp;
    apply_reset();
    shadow = mem_arr;
    exp_q.delete();
    free_at = 0; g_edge = 0; streak = 0; active = 1'b0;
    g_instr = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
    exp_instr = '0; exp_data = '0;
    for (int e = 0; e < n; e++) begin
      @(posedge clock);
      if (!active && e >= free_at && (instrmem_rd || data_req)) begin
        active = 1'b1; g_edge = e;
        if (instrmem_rd && (!data_req || (SMAX != 0 && streak == SMAX))) begin
          g_instr = 1'b1; g_we = 1'b0; g_addr = pc; streak = 0;
          exp_q.push_back({1'b1, shadow_peek(pc)});
        end else begin
          g_instr = 1'b0; g_we = !Data_rd; g_addr = Data_addr; g_wdata = Data_din;
          streak = instrmem_rd ? ((streak < SMAX) ? streak + 1 : streak) : 0;
          if (g_we) shadow[Data_addr] = Data_din;
          exp_q.push_back({1'b0, g_we ? exp_data : shadow_peek(Data_addr)});
        end
      end
      @(negedge clock);
      c = e + 1;
      en   = active && (c <= g_edge + LAT);
      done = active && (c == g_edge + LAT + 1);
      if (done) begin
        item = exp_q.pop_front();
        if (item[16]) exp_instr = item[15:0];
        else          exp_data  = item[15:0];
      end
      exp = {en, en && g_we, active, done && g_instr, done && !g_instr};
      checks++;
      if (ctl_m !== exp) begin
        errors++;
        $display("FAIL rand_ctl cycle=%0d got=%b required=%b", c, ctl_m, exp);
      end
      if (en) begin
        checks++;
        if (m_if.mem_addr !== g_addr || (g_we && m_if.mem_wdata !== g_wdata)) begin
          errors++;
          $display("FAIL rand_bus cycle=%0d got=%h/%h required=%h/%h", c, m_if.mem_addr, m_if.mem_wdata, g_addr, g_wdata);
        end
      end
      checks++;
      if (m_if.Instr_dout !== exp_instr || m_if.Data_dout !== exp_data) begin
        errors++;
        $display("FAIL rand_dout cycle=%0d got=%h/%h required=%h/%h", c, m_if.Instr_dout, m_if.Data_dout, exp_instr, exp_data);
      end
      if (done) begin
        active = 1'b0;
        free_at = e + 2;
        if (g_instr) begin
          instrmem_rd = 1'($urandom_range(0, 1));
          pc = 16'h4000 + 16'($urandom_range(0, 3));
        end else begin
          data_req = 1'($urandom_range(0, 1));
          Data_rd = 1'($urandom_range(0, 1));
          Data_addr = 16'h4000 + 16'($urandom_range(0, 3));
          Data_din = 16'($urandom);
        end
      end else begin
        if (!instrmem_rd && $urandom_range(0, 3) == 0) begin
          instrmem_rd = 1'b1;
          pc = 16'h4000 + 16'($urandom_range(0, 3));
        end
        if (!data_req && $urandom_range(0, 2) == 0) begin
          data_req = 1'b1;
          Data_rd = 1'($urandom_range(0, 1));
          Data_addr = 16'h4000 + 16'($urandom_range(0, 3));
          Data_din = 16'($urandom);
        end
      end
    end
    instrmem_rd = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_priority();
    test_starvation();
    test_reset_mid_access();
    test_back_to_back();
    test_random(800);
    repeat (4) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
